// File: rtl/alu_mc_unit_pkg.sv
// Shared types for the multi-cycle ALU: opcodes, operand signedness and the
// instruction word presented on the input handshake.
package definitions;

  localparam int DATA_WIDTH = 32;

  typedef logic [DATA_WIDTH-1:0] data_t;

  typedef enum logic [1:0] {
    ADD  = 2'd0,
    SUB  = 2'd1,
    MULT = 2'd2,
    RSVD = 2'd3
  } opcode_t;

  typedef enum logic {
    UNSIGNED = 1'b0,
    SIGNED   = 1'b1
  } operand_type_t;

  typedef struct packed {
    opcode_t       opc;
    operand_type_t op_type;
    data_t         op_a;
    data_t         op_b;
  } instruction_t;

endpackage

// File: rtl/alu_mc_unit_mult.sv
// Iterative shift-add multiplier: one partial product per cycle on operand
// magnitudes, sign applied to the final combinational product.
module alu_mult_seq
  import definitions::*;
#(
  parameter int DATA_W = DATA_WIDTH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic [DATA_W-1:0]   a_i,
  input  logic [DATA_W-1:0]   b_i,
  input  logic                sign_i,
  output logic                busy_o,
  output logic                done_o,
  output logic [2*DATA_W-1:0] product_o
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

  logic [2*DATA_W:0]   prod_q;
  logic [DATA_W-1:0]   mcand_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                busy_q;
  logic                neg_q;

  logic [DATA_W-1:0]   absA, absB;
  logic [DATA_W:0]     sumHi;
  logic [2*DATA_W-1:0] prodStep;

  assign absA = (sign_i && a_i[DATA_W-1]) ? -a_i : a_i;
  assign absB = (sign_i && b_i[DATA_W-1]) ? -b_i : b_i;

  // Upper half accumulates the multiplicand when the current multiplier bit
  // is set; the whole register then shifts right by one.
  always_comb begin
    sumHi    = prod_q[2*DATA_W:DATA_W] + (prod_q[0] ? {1'b0, mcand_q} : '0);
    prodStep = {sumHi, prod_q[DATA_W-1:1]};
  end

  assign busy_o    = busy_q;
  assign done_o    = busy_q && (cnt_q == LAST_CNT);
  assign product_o = neg_q ? -prodStep : prodStep;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod_q  <= '0;
      mcand_q <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      neg_q   <= 1'b0;
    end else if (busy_q) begin
      prod_q <= {1'b0, prodStep};
      cnt_q  <= cnt_q + 1'b1;
      if (cnt_q == LAST_CNT) begin
        busy_q <= 1'b0;
      end
    end else if (start_i) begin
      prod_q  <= {{(DATA_W+1){1'b0}}, absB};
      mcand_q <= absA;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
      neg_q   <= sign_i && (a_i[DATA_W-1] ^ b_i[DATA_W-1]);
    end
  end

endmodule

// File: rtl/alu_mc_unit.sv
// Multi-cycle ALU: single-cycle add/sub, iterative multiply, one-deep output
// register with valid/ready backpressure.
module alu_mc_unit
  import definitions::*;
#(
  parameter int DATA_W = DATA_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  instruction_t      instr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] alu_out,
  output logic              ovf,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, MUL, HOLD} state_t;

  state_t              state_q;
  logic                outValid_q, ovf_q, err_q, mulSigned_q, holdOvf_q;
  logic [DATA_W-1:0]   aluOut_q, holdOut_q;

  logic                accept, mulStart, mulBusy, mulDone, outFree, isSigned;
  logic [2*DATA_W-1:0] mulProd;
  logic [DATA_W-1:0]   opA, opB, diff, res_d;
  logic [DATA_W:0]     sum;
  logic                ovf_d, err_d, mulOvf;

  assign opA      = instr.op_a;
  assign opB      = instr.op_b;
  assign isSigned = (instr.op_type == SIGNED);
  assign outFree  = !outValid_q || out_ready;
  assign in_ready = (state_q == IDLE) && !mulBusy && outFree;
  assign accept   = in_valid && in_ready;
  assign mulStart = accept && (instr.opc == MULT);

  always_comb begin
    sum   = {1'b0, opA} + {1'b0, opB};
    diff  = opA - opB;
    res_d = '0;
    ovf_d = 1'b0;
    err_d = 1'b0;
    case (instr.opc)
      ADD: begin
        res_d = sum[DATA_W-1:0];
        ovf_d = isSigned ? ((opA[DATA_W-1] == opB[DATA_W-1]) && (sum[DATA_W-1] != opA[DATA_W-1]))
                         : sum[DATA_W];
      end
      SUB: begin
        res_d = diff;
        ovf_d = isSigned ? ((opA[DATA_W-1] != opB[DATA_W-1]) && (diff[DATA_W-1] != opA[DATA_W-1]))
                         : (opA < opB);
      end
      MULT: ;
      default: err_d = 1'b1;
    endcase
  end

  // Signed products overflow when the upper half is not a pure sign extension.
  assign mulOvf = mulSigned_q ? (mulProd[2*DATA_W-1:DATA_W] != {DATA_W{mulProd[DATA_W-1]}})
                              : (|mulProd[2*DATA_W-1:DATA_W]);

  alu_mult_seq #(.DATA_W(DATA_W)) uMult (
    .clk       (clk),
    .rst       (rst),
    .start_i   (mulStart),
    .a_i       (opA),
    .b_i       (opB),
    .sign_i    (isSigned),
    .busy_o    (mulBusy),
    .done_o    (mulDone),
    .product_o (mulProd)
  );

  // A drain clears out_valid unless a new result lands on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      outValid_q  <= 1'b0;
      aluOut_q    <= '0;
      ovf_q       <= 1'b0;
      err_q       <= 1'b0;
      mulSigned_q <= 1'b0;
      holdOut_q   <= '0;
      holdOvf_q   <= 1'b0;
    end else begin
      if (out_ready) begin
        outValid_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (instr.opc == MULT) begin
              state_q     <= MUL;
              mulSigned_q <= isSigned;
            end else begin
              outValid_q <= 1'b1;
              aluOut_q   <= res_d;
              ovf_q      <= ovf_d;
              err_q      <= err_d;
            end
          end
        end
        MUL: begin
          if (mulDone) begin
            if (outFree) begin
              outValid_q <= 1'b1;
              aluOut_q   <= mulProd[DATA_W-1:0];
              ovf_q      <= mulOvf;
              err_q      <= 1'b0;
              state_q    <= IDLE;
            end else begin
              holdOut_q <= mulProd[DATA_W-1:0];
              holdOvf_q <= mulOvf;
              state_q   <= HOLD;
            end
          end
        end
        HOLD: begin
          if (out_ready && outValid_q) begin
            outValid_q <= 1'b1;
            aluOut_q   <= holdOut_q;
            ovf_q      <= holdOvf_q;
            err_q      <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid = outValid_q;
  assign alu_out   = aluOut_q;
  assign ovf       = ovf_q;
  assign err       = err_q;

endmodule

// File: tb/tb_alu_mc_unit.sv
// Scoreboard bench for alu_mc_unit: directed vectors push expected results,
// a monitor pops and compares on every output handshake.
module tb_alu_mc_unit;
  import definitions::*;

  localparam int W = 32;

  typedef struct packed {
    logic [W-1:0] res;
    logic         ovf;
    logic         err;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  instruction_t instr;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] alu_out;
  logic         ovf;
  logic         err;

  int   cmpCount  = 0;
  int   failCount = 0;
  exp_t expQ[$];

  alu_mc_unit #(.DATA_W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .instr     (instr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .alu_out   (alu_out),
    .ovf       (ovf),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    cmpCount++;
    if (actual !== required) begin
      failCount++;
      $display("[TB] FAIL %s: actual=%h required=%h", name, actual, required);
    end
  endtask

  // Holds the instruction until accepted, then records the expected result.
  task automatic applyStimulus(input opcode_t op, input operand_type_t ty,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] expRes, input logic expOvf, input logic expErr);
    int waitCycles = 0;
    exp_t e;
    instr.opc     = op;
    instr.op_type = ty;
    instr.op_a    = a;
    instr.op_b    = b;
    in_valid      = 1'b1;
    @(negedge clk);
    while (!in_ready && waitCycles < 200) begin
      @(negedge clk);
      waitCycles++;
    end
    if (!in_ready) begin
      cmpCount++;
      failCount++;
      $display("[TB] FAIL acceptTimeout: actual in_ready=0 required in_ready=1 within 200 cycles");
    end else begin
      e.res = expRes;
      e.ovf = expOvf;
      e.err = expErr;
      expQ.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic waitDrain();
    int c = 0;
    while (expQ.size() != 0 && c < 200) begin
      @(negedge clk);
      c++;
    end
    if (expQ.size() != 0) begin
      cmpCount++;
      failCount++;
      $display("[TB] FAIL drainTimeout: actual pending=%0d required pending=0", expQ.size());
      expQ.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        cmpCount++;
        if (expQ.size() == 0) begin
          failCount++;
          $display("[TB] FAIL unexpectedResult: actual alu_out=%h ovf=%b err=%b required no result",
                   alu_out, ovf, err);
        end else begin
          e = expQ.pop_front();
          if (alu_out !== e.res || ovf !== e.ovf || err !== e.err) begin
            failCount++;
            $display("[TB] FAIL result: actual alu_out=%h ovf=%b err=%b required alu_out=%h ovf=%b err=%b",
                     alu_out, ovf, err, e.res, e.ovf, e.err);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: actual run still active required completion");
    $fatal(1, "[TB] simulation timeout");
  end

  initial begin : stimulus
    int n;
    int lowCnt;
    int validSeen;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    instr     = '0;
    #12;
    checkOutput("resetOutValid", out_valid, 0);
    checkOutput("resetAluOut", alu_out, 0);
    checkOutput("resetOvfErr", {ovf, err}, 0);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    out_ready = 1'b1;

    // Single-cycle ops issued back to back, including boundary overflows.
    applyStimulus(ADD,  UNSIGNED, 32'd5,         32'd3,         32'd8,         1'b0, 1'b0);
    applyStimulus(SUB,  UNSIGNED, 32'd5,         32'd3,         32'd2,         1'b0, 1'b0);
    applyStimulus(ADD,  UNSIGNED, 32'hFFFF_FFFF, 32'd1,         32'd0,         1'b1, 1'b0);
    applyStimulus(ADD,  SIGNED,   32'h7FFF_FFFF, 32'd1,         32'h8000_0000, 1'b1, 1'b0);
    applyStimulus(ADD,  SIGNED,   32'hFFFF_FFFF, 32'd1,         32'd0,         1'b0, 1'b0);
    applyStimulus(SUB,  UNSIGNED, 32'd3,         32'd5,         32'hFFFF_FFFE, 1'b1, 1'b0);
    applyStimulus(SUB,  SIGNED,   32'h8000_0000, 32'd1,         32'h7FFF_FFFF, 1'b1, 1'b0);
    applyStimulus(RSVD, UNSIGNED, 32'd7,         32'd9,         32'd0,         1'b0, 1'b1);
    applyStimulus(ADD,  UNSIGNED, 32'd2,         32'd2,         32'd4,         1'b0, 1'b0);
    waitDrain();

    // Multiply latency: in_ready low for W cycles, result visible W+1 after accept.
    applyStimulus(MULT, UNSIGNED, 32'd12, 32'd3, 32'd36, 1'b0, 1'b0);
    n = 0;
    lowCnt = 0;
    do begin
      @(negedge clk);
      n++;
      if (!in_ready) lowCnt++;
    end while (!out_valid && n < 100);
    checkOutput("multLatency", n, W + 1);
    checkOutput("multReadyLow", lowCnt, W);
    waitDrain();

    applyStimulus(MULT, SIGNED,   32'hFFFF_FFFC, 32'd3,         32'hFFFF_FFF4, 1'b0, 1'b0);
    applyStimulus(MULT, UNSIGNED, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFE, 1'b1, 1'b0);
    applyStimulus(MULT, SIGNED,   32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 1'b0);
    applyStimulus(MULT, SIGNED,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,         1'b0, 1'b0);
    applyStimulus(MULT, UNSIGNED, 32'd0,         32'd12345,     32'd0,         1'b0, 1'b0);
    waitDrain();

    // Backpressure: result must stay frozen while a multiply waits at the input.
    out_ready = 1'b0;
    applyStimulus(ADD, UNSIGNED, 32'd10, 32'd20, 32'd30, 1'b0, 1'b0);
    instr.opc     = MULT;
    instr.op_type = UNSIGNED;
    instr.op_a    = 32'd7;
    instr.op_b    = 32'd6;
    in_valid      = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("stallValid", out_valid, 1);
      checkOutput("stallAluOut", alu_out, 32'd30);
      checkOutput("stallReady", in_ready, 0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    applyStimulus(MULT, UNSIGNED, 32'd7, 32'd6, 32'd42, 1'b0, 1'b0);
    waitDrain();

    // Asynchronous reset in the middle of a multiply discards it.
    applyStimulus(MULT, UNSIGNED, 32'd9, 32'd9, 32'd81, 1'b0, 1'b0);
    repeat (9) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checkOutput("midRstValid", out_valid, 0);
    checkOutput("midRstAluOut", alu_out, 0);
    expQ.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("postRstReady", in_ready, 1);
    validSeen = 0;
    repeat (W + 4) begin
      @(negedge clk);
      if (out_valid) validSeen++;
    end
    checkOutput("noStaleProduct", validSeen, 0);
    @(posedge clk);
    #1;
    applyStimulus(ADD, UNSIGNED, 32'd1, 32'd1, 32'd2, 1'b0, 1'b0);
    waitDrain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, failCount);
    $finish;
  end

endmodule
